pio_edge_capture: RTL

PIO_EDGE_CAPTURE -- requirements
Module: pio_edge_capture

---
 rtl/pio_edge_capture.sv | 109 ++++++++++
 1 files changed

// File: rtl/pio_edge_capture.sv
// rtl/pio_edge_capture.sv - Avalon-MM PIO with input sync, edge capture and optional IRQ (macro PIO_EDGE_CAPTURE_IRQ_EN)
module pio_edge_capture #(
  parameter int WIDTH     = 8,
  parameter int EDGE_TYPE = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clear_bits;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] irqmask;
  logic [31:0]      read_mux;
  logic             wr_en;
  logic             unused_writedata;

  assign wr_en = chipselect & ~write_n;

  // Upper writedata bits beyond WIDTH carry no meaning for this block.
  assign unused_writedata = &{1'b0, writedata};

  // Two-flop synchronizer, plus a one-cycle delayed copy for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Edge selection fixed at elaboration by EDGE_TYPE.
  always_comb begin
    edge_det = '0;
    case (EDGE_TYPE)
      0:       edge_det = sync2 & ~prev;
      1:       edge_det = ~sync2 & prev;
      default: edge_det = sync2 ^ prev;
    endcase
  end

  // Write-1-to-clear mask for the capture register.
  always_comb begin
    clear_bits = '0;
    if (wr_en && (address == 2'd3)) begin
      clear_bits = writedata[WIDTH-1:0];
    end
  end

  // Sticky capture; a fresh edge overrides a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edgecapture <= '0;
    end else begin
      edgecapture <= (edgecapture & ~clear_bits) | edge_det;
    end
  end

`ifdef PIO_EDGE_CAPTURE_IRQ_EN
  // Interrupt mask register, written through address 2.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask <= '0;
    end else if (wr_en && (address == 2'd2)) begin
      irqmask <= writedata[WIDTH-1:0];
    end
  end

  assign irq = |(edgecapture & irqmask);
`else
  assign irqmask = '0;
  assign irq     = 1'b0;
`endif

  // Address decode for reads, zero-extended to the bus width.
  always_comb begin
    read_mux = '0;
    case (address)
      2'd0:    read_mux[WIDTH-1:0] = sync2;
      2'd2:    read_mux[WIDTH-1:0] = irqmask;
      2'd3:    read_mux[WIDTH-1:0] = edgecapture;
      default: read_mux = '0;
    endcase
  end

  // Registered read data, refreshed every cycle with no read strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= read_mux;
    end
  end

endmodule
